// File: rtl/out_uart.sv
// Word-wide FIFO feeding a UART 8N1 transmitter. Each 32-bit word is sent as four bytes, least-significant byte first.
//   clk       : single clock, rising edge
//   reset     : asynchronous, active-low
//   din       : word to transmit
//   din_valid : write strobe, one word per cycle
//   tx        : serial line, idle high (registered)
//   busy      : serializer not idle (registered)
//   full      : FIFO holds DEPTH words (registered)
//   empty     : FIFO holds no words (registered)
//   overflow  : sticky, a word was written while full
// DEPTH must be a power of two >= 2; CLKS_PER_BIT must be >= 2.
module out_uart #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        tx,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  logic              push;
  logic              pop;

  // Serializer state
  state_t            state;
  state_t            state_d;
  logic [BAUD_W-1:0] baud;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_d;
  logic [1:0]        byte_idx;
  logic [1:0]        byte_idx_d;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] shift_d;
  logic              baud_end;
  logic              tx_d;
  logic              busy_d;

  // A write while full is dropped even if a pop frees a slot in the same cycle
  assign push = din_valid & ~full;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CNT_W'(1);
      2'b01:   count_d = count - CNT_W'(1);
      default: count_d = count;
    endcase
  end

  // FIFO data array: no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // FIFO pointers, count and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
      empty <= (count_d == '0);
      if (din_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Serializer next-state logic
  always_comb begin
    state_d    = state;
    baud_d     = baud;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    shift_d    = shift;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = mem[rd_ptr];
          bit_idx_d  = 3'd0;
          byte_idx_d = 2'd0;
          baud_d     = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift[WORD_W-1:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_idx < 2'd3) begin
            byte_idx_d = byte_idx + 2'd1;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // tx and busy are registered from next-state values so they line up with the state they describe
    tx_d = 1'b1;
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shift_d[0];
    end
    busy_d = (state_d != S_IDLE);
  end

  // Serializer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_out_uart.sv
// Testbench for out_uart: scoreboard of expected bytes fed by stimulus, UART decoder monitor comparing received bytes.
module tb_out_uart;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        tx, busy, full, empty, overflow;

  out_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .tx        (tx),
    .busy      (busy),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a word leaves the line as its four bytes, low byte first
  task automatic push_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(w >> (8 * i)));
  endtask

  // UART 8N1 decoder sampling each bit at its centre
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) begin
        check("start_bit", {31'd0, tx}, 32'd0);
      end else if (mon_cnt > CPB && mon_cnt < 9 * CPB && ((mon_cnt - CPB / 2) % CPB) == 0) begin
        mon_byte = {tx, mon_byte[7:1]};
      end else if (mon_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_byte: got unexpected 0x%0h, expected nothing", mon_byte);
        end else begin
          check("rx_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    repeat (3) @(negedge clk);
    while (!(empty === 1'b1 && busy === 1'b0 && !mon_active) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'd0, (k < 3000)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          bad;
    int          k;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: latency, busy window, byte spacing
    start_q.delete();
    din = 32'h44332211; din_valid = 1'b1; push_exp(din);
    @(negedge clk); din_valid = 1'b0;
    check("sw_tx_c1", {31'd0, tx}, 32'd1);
    check("sw_empty_c1", {31'd0, empty}, 32'd0);
    @(negedge clk);
    check("sw_tx_c2", {31'd0, tx}, 32'd0);
    check("sw_empty_c2", {31'd0, empty}, 32'd1);
    check("sw_busy_c2", {31'd0, busy}, 32'd1);
    repeat (159) @(negedge clk);
    check("sw_busy_c161", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("sw_busy_c162", {31'd0, busy}, 32'd0);
    check("sw_tx_c162", {31'd0, tx}, 32'd1);
    wait_drain("sw_drain");
    check("sw_nbytes", start_q.size(), 32'd4);
    if (start_q.size() == 4) check("sw_byte_gap", start_q[1] - start_q[0], 32'd40);

    // Fill: ten consecutive writes, tenth dropped
    for (int i = 1; i <= 10; i++) begin
      din = 32'(i); din_valid = 1'b1;
      if (i <= 9) push_exp(din);
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_overflow", {31'd0, overflow}, 32'd1);
    wait_drain("fill_drain");
    check("fill_ovf_sticky", {31'd0, overflow}, 32'd1);
    do_reset();
    check("fill_ovf_cleared", {31'd0, overflow}, 32'd0);

    // Back-to-back words: one idle cycle between words
    start_q.delete();
    din = 32'hA5A5A5A5; din_valid = 1'b1; push_exp(din);
    @(negedge clk);
    din = 32'h5A5A5A5A; push_exp(din);
    @(negedge clk); din_valid = 1'b0;
    wait_drain("b2b_drain");
    check("b2b_nbytes", start_q.size(), 32'd8);
    if (start_q.size() == 8) begin
      check("b2b_word_span", start_q[3] - start_q[0], 32'd120);
      check("b2b_word_gap", start_q[4] - start_q[3], 32'd41);
    end

    // Reset in the middle of byte 1 with three words queued
    start_q.delete();
    for (int i = 0; i < 4; i++) begin
      w = $urandom; din = w; din_valid = 1'b1; push_exp(w);
      @(negedge clk);
    end
    din_valid = 1'b0;
    k = 0;
    while (start_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
    check("mid_reach_byte1", {31'd0, (k < 200)}, 32'd1);
    repeat (10) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_tx", {31'd0, tx}, 32'd1);
    check("mid_empty", {31'd0, empty}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("mid_quiet_cycles_bad", 32'(bad), 32'd0);
    check("mid_nstarts", start_q.size(), 32'd2);

    // Push/pop collision: count stays 1
    w = $urandom; din = w; din_valid = 1'b1; push_exp(w);
    @(negedge clk);
    w = $urandom; din = w; push_exp(w);
    @(negedge clk); din_valid = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    check("col_reach_idle", {31'd0, (k < 400)}, 32'd1);
    check("col_empty_idle", {31'd0, empty}, 32'd0);
    w = $urandom; din = w; din_valid = 1'b1; push_exp(w);
    @(negedge clk); din_valid = 1'b0;
    check("col_busy", {31'd0, busy}, 32'd1);
    check("col_empty", {31'd0, empty}, 32'd0);
    check("col_full", {31'd0, full}, 32'd0);
    check("col_overflow", {31'd0, overflow}, 32'd0);
    wait_drain("col_drain");

    // Random bursts that never exceed the FIFO
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        int gap;
        w = $urandom; din = w; din_valid = 1'b1; push_exp(w);
        @(negedge clk);
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          din_valid = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end
      din_valid = 1'b0;
      wait_drain("rand_drain");
    end
    check("rand_overflow", {31'd0, overflow}, 32'd0);
    check("final_exp_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
